// File: rtl/scntr_ctrl_pkg.sv
// scntr_ctrl_pkg
//   Shared definitions for the scntr measurement-window sequencer: FSM state
//   encoding and default sizing. The ADPLL top imports the same defaults so
//   its window-sizing checks agree with the controller.
package scntr_ctrl_pkg;

  // Default scntr output width, window-length width and clear-hold length.
  // The clear hold reuses the window timer, so WIN_W must be able to hold
  // CLR_CYC_DEF-1 (40 cycles x 5 ns = 200 ns of settling for the MUX chain).
  localparam int CNT_W_DEF   = 4;
  localparam int WIN_W_DEF   = 8;
  localparam int CLR_CYC_DEF = 40;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RUN     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

endpackage

// File: rtl/scntr_ctrl_if.sv
// scntr_ctrl_if
//   Bundles the request/result handshake and the scntr control/status wires.
//   slave  : the sequencer (scntr_ctrl)
//   master : the environment (loop-filter logic requesting windows plus the
//            scntr instance returning count/overflow)
//   Signals
//     start, win, abort : window request, length in cycles, cancel
//     cnt, flw          : scntr o_out / o_flw
//     cnt_en, cnt_in    : scntr i_en / i_in
//     cnt_rst           : scntr i_rst
//     busy, done        : sequencer status, one-cycle result strobe
//     result, ovf       : captured count and overflow
interface scntr_ctrl_if
  import scntr_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
);

  logic             start;
  logic [WIN_W-1:0] win;
  logic             abort;
  logic [CNT_W-1:0] cnt;
  logic             flw;
  logic             cnt_en;
  logic             cnt_in;
  logic             cnt_rst;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] result;
  logic             ovf;

  modport slave (
    input  start, win, abort, cnt, flw,
    output cnt_en, cnt_in, cnt_rst, busy, done, result, ovf
  );

  modport master (
    output start, win, abort, cnt, flw,
    input  cnt_en, cnt_in, cnt_rst, busy, done, result, ovf
  );

endinterface

// File: rtl/scntr_ctrl_tmr.sv
// scntr_ctrl_tmr
//   Loadable down-counter shared between the measurement window and the
//   post-window clear hold. Load wins over decrement; the count stops at zero.
//   Ports
//     i_clk, i_rst : clock, synchronous active-high reset (loads RST_VAL)
//     load         : load load_val this cycle
//     load_val     : value to load
//     dec          : decrement this cycle (ignored at zero)
//     zero         : count is zero (combinational from the register)
module scntr_ctrl_tmr
  import scntr_ctrl_pkg::*;
#(
  parameter int           W       = WIN_W_DEF,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/scntr_ctrl.sv
// scntr_ctrl
//   Measurement-window sequencer for the ADPLL scntr counter. A start request
//   in IDLE enables the counter for exactly win cycles, waits one cycle for
//   the scntr output latency, captures count and sticky overflow, then holds
//   the counter in reset for CLR_CYC cycles before accepting the next window.
//   A zero-length request returns an immediate zero result without touching
//   the counter. All outputs are registered.
//   Ports
//     i_clk : system clock (200 MHz)
//     i_rst : synchronous reset, active-high; also aborts a running window
//     bus   : scntr_ctrl_if.slave (start/win/abort in, cnt/flw from scntr,
//             cnt_en/cnt_in/cnt_rst to scntr, busy/done/result/ovf out)
module scntr_ctrl
  import scntr_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int WIN_W   = WIN_W_DEF,
  parameter int CLR_CYC = CLR_CYC_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  scntr_ctrl_if.slave  bus
);

  // The timer holds N-1 to time N cycles, for both the window and the hold.
  localparam logic [WIN_W-1:0] CLR_LOAD = WIN_W'(CLR_CYC - 1);

  state_t           state;
  logic             ovf_sticky;
  logic             tmr_load;
  logic             tmr_dec;
  logic [WIN_W-1:0] tmr_val;
  logic             tmr_zero;

  // Timer control follows the same decisions the FSM makes this cycle so the
  // count is already loaded when the next state begins.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_CLEAR: begin
        tmr_dec = 1'b1;
      end
      ST_IDLE: begin
        if (bus.start && (bus.win != '0)) begin
          tmr_load = 1'b1;
          tmr_val  = bus.win - 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          tmr_load = 1'b1;
          tmr_val  = CLR_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SETTLE, ST_CAPTURE: begin
        tmr_load = 1'b1;
        tmr_val  = CLR_LOAD;
      end
      default: begin
        tmr_load = 1'b1;
        tmr_val  = CLR_LOAD;
      end
    endcase
  end

  scntr_ctrl_tmr #(
    .W       (WIN_W),
    .RST_VAL (CLR_LOAD)
  ) u_tmr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Sequencer FSM with registered outputs. done defaults low so it is a
  // single-cycle strobe; result/ovf only change when done is raised.
  // Overflow is sticky across RUN and SETTLE so a wrap anywhere in the window
  // is reported even if the final count looks small.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_CLEAR;
      ovf_sticky  <= 1'b0;
      bus.cnt_en  <= 1'b0;
      bus.cnt_in  <= 1'b0;
      bus.cnt_rst <= 1'b1;
      bus.busy    <= 1'b1;
      bus.done    <= 1'b0;
      bus.result  <= '0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_CLEAR: begin
          bus.cnt_en  <= 1'b0;
          bus.cnt_in  <= 1'b0;
          bus.cnt_rst <= 1'b1;
          bus.busy    <= 1'b1;
          if (tmr_zero) begin
            state       <= ST_IDLE;
            bus.cnt_rst <= 1'b0;
            bus.busy    <= 1'b0;
          end
        end
        ST_IDLE: begin
          bus.cnt_rst <= 1'b0;
          bus.busy    <= 1'b0;
          if (bus.start) begin
            if (bus.win != '0) begin
              state      <= ST_RUN;
              ovf_sticky <= 1'b0;
              bus.cnt_en <= 1'b1;
              bus.cnt_in <= 1'b1;
              bus.busy   <= 1'b1;
            end else begin
              // Empty window: report a zero result without running scntr.
              bus.done   <= 1'b1;
              bus.result <= '0;
              bus.ovf    <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          ovf_sticky <= ovf_sticky | bus.flw;
          if (bus.abort) begin
            state       <= ST_CLEAR;
            bus.cnt_en  <= 1'b0;
            bus.cnt_in  <= 1'b0;
            bus.cnt_rst <= 1'b1;
          end else if (tmr_zero) begin
            state      <= ST_SETTLE;
            bus.cnt_en <= 1'b0;
            bus.cnt_in <= 1'b0;
          end
        end
        ST_SETTLE: begin
          ovf_sticky <= ovf_sticky | bus.flw;
          if (bus.abort) begin
            state       <= ST_CLEAR;
            bus.cnt_rst <= 1'b1;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          bus.result  <= bus.cnt;
          bus.ovf     <= ovf_sticky | bus.flw;
          bus.done    <= 1'b1;
          bus.cnt_rst <= 1'b1;
          state       <= ST_CLEAR;
        end
        default: begin
          state       <= ST_CLEAR;
          bus.cnt_en  <= 1'b0;
          bus.cnt_in  <= 1'b0;
          bus.cnt_rst <= 1'b1;
          bus.busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scntr_ctrl.sv
`timescale 1ns/100ps
// tb_scntr_ctrl
//   Drives scntr_ctrl through directed windows with a behavioural scntr
//   stand-in. Expected outputs come from a timeline model: each accepted
//   request writes the whole future waveform (enable span, hold span, done
//   strobe, result) into per-cycle arrays that one compare process checks.
module tb_scntr_ctrl;

  localparam int CNT_W   = 4;
  localparam int WIN_W   = 8;
  localparam int CLR_CYC = 40;
  localparam int N       = 4096;
  localparam int MODV    = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  scntr_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  scntr_ctrl #(
    .CNT_W   (CNT_W),
    .WIN_W   (WIN_W),
    .CLR_CYC (CLR_CYC)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #2.5 clk = ~clk;

  // cyc equals the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural scntr: counts enabled cycles, one-cycle flw pulse on wrap.
  logic [CNT_W-1:0] cnt_q = '0;
  logic             flw_q = 1'b0;
  always @(posedge clk) begin
    if (bus.cnt_rst === 1'b1) begin
      cnt_q <= '0;
      flw_q <= 1'b0;
    end else if ((bus.cnt_en === 1'b1) && (bus.cnt_in === 1'b1)) begin
      cnt_q <= cnt_q + 1'b1;
      flw_q <= (cnt_q == '1);
    end else begin
      flw_q <= 1'b0;
    end
  end
  assign bus.cnt = cnt_q;
  assign bus.flw = flw_q;

  // Expected outputs after rising edge j.
  bit               exp_en   [N];
  bit               exp_rst  [N];
  bit               exp_busy [N];
  bit               exp_done [N];
  bit               exp_ovf  [N];
  logic [CNT_W-1:0] exp_res  [N];
  int idle_from = N;
  int win_start = 0;
  int win_len   = 0;
  bit win_act   = 1'b0;
  int chk_from  = N;

  task automatic setResult(input int from, input logic [CNT_W-1:0] r, input bit o);
    for (int j = from; j < N; j++) begin
      exp_res[j] = r;
      exp_ovf[j] = o;
    end
  endtask

  task automatic mdlClear(input int k);
    for (int j = k; j < N; j++) begin
      exp_rst[j]  = (j < k + CLR_CYC);
      exp_busy[j] = (j < k + CLR_CYC);
      exp_en[j]   = 1'b0;
      exp_done[j] = 1'b0;
    end
    idle_from = k + CLR_CYC;
  endtask

  // Apply the request seen at rising edge k to the expected timeline.
  task automatic mdlStep(input bit r, input bit s, input int w, input bit a, input int k);
    if (r) begin
      mdlClear(k);
      setResult(k, '0, 1'b0);
      win_act = 1'b0;
      if (k < chk_from) chk_from = k;
    end else if (s && (k - 1 >= idle_from)) begin
      if (w == 0) begin
        exp_done[k] = 1'b1;
        setResult(k, '0, 1'b0);
      end else begin
        for (int j = k; j <= k + w + 1; j++) begin
          exp_en[j]   = (j < k + w);
          exp_busy[j] = 1'b1;
          exp_rst[j]  = 1'b0;
          exp_done[j] = 1'b0;
        end
        mdlClear(k + w + 2);
        exp_done[k + w + 2] = 1'b1;
        setResult(k + w + 2, CNT_W'(w % MODV), (w >= MODV));
        win_start = k;
        win_len   = w;
        win_act   = 1'b1;
      end
    end else if (a && win_act && (k - 1 >= win_start) && (k - 1 <= win_start + win_len)) begin
      mdlClear(k);
      setResult(k, exp_res[k - 1], exp_ovf[k - 1]);
      win_act = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // Drive one cycle of inputs (sampled at the next rising edge), then
  // return 1 ns after that edge with the inputs released.
  task automatic applyStimulus(input bit s, input logic [WIN_W-1:0] w, input bit a, input bit r);
    mdlStep(r, s, int'(w), a, cyc + 1);
    rst       = r;
    bus.start = s;
    bus.win   = w;
    bus.abort = a;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.win   = '0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count consecutive cycles with cnt_rst high, starting with the current one.
  task automatic countRst(output int n);
    n = 0;
    while ((bus.cnt_rst === 1'b1) && (n < 400)) begin
      n++;
      idleCycles(1);
    end
  endtask

  // Start a window and follow it to done. Latency counts the cycle after the
  // start edge as 1. Optionally poke start/abort once at cycle poke_at.
  task automatic runWindow(input logic [WIN_W-1:0] w, input int poke_at, input bit poke_s,
                           input bit poke_a, output int lat, output int en_cnt, output int rst_cnt);
    applyStimulus(1'b1, w, 1'b0, 1'b0);
    lat    = 1;
    en_cnt = 0;
    while ((bus.done !== 1'b1) && (lat < 400)) begin
      if (bus.cnt_en === 1'b1) en_cnt++;
      if (lat == poke_at) applyStimulus(poke_s, 8'd3, poke_a, 1'b0);
      else idleCycles(1);
      lat++;
    end
    checkOutput("done_seen", 32'(bus.done), 32'd1);
    countRst(rst_cnt);
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clk) begin
    if ((cyc >= chk_from) && (cyc < N)) begin
      checkOutput("cnt_en",  32'(bus.cnt_en),  32'(exp_en[cyc]));
      checkOutput("cnt_in",  32'(bus.cnt_in),  32'(exp_en[cyc]));
      checkOutput("cnt_rst", 32'(bus.cnt_rst), 32'(exp_rst[cyc]));
      checkOutput("busy",    32'(bus.busy),    32'(exp_busy[cyc]));
      checkOutput("done",    32'(bus.done),    32'(exp_done[cyc]));
      checkOutput("result",  32'(bus.result),  32'(exp_res[cyc]));
      checkOutput("ovf",     32'(bus.ovf),     32'(exp_ovf[cyc]));
    end
  end

  initial begin
    #100us;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  int lat, en_cnt, rst_cnt;
  logic [WIN_W-1:0] tbl_win [4] = '{8'd1, 8'd15, 8'd16, 8'd255};
  int               tbl_res [4] = '{1, 15, 0, 15};
  int               tbl_ovf [4] = '{0, 0, 1, 1};

  initial begin
    bus.start = 1'b0;
    bus.win   = '0;
    bus.abort = 1'b0;
    idleCycles(2);

    // Reset: clear hold of exactly CLR_CYC cycles, then idle.
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd1);
    checkOutput("rst_result", 32'(bus.result), 32'd0);
    countRst(rst_cnt);
    checkOutput("post_reset_hold", 32'(rst_cnt), 32'd40);
    checkOutput("post_reset_idle", 32'(bus.busy), 32'd0);

    // Plain window of 10.
    runWindow(8'd10, 0, 1'b0, 1'b0, lat, en_cnt, rst_cnt);
    checkOutput("w10_latency", 32'(lat), 32'd13);
    checkOutput("w10_en_cycles", 32'(en_cnt), 32'd10);
    checkOutput("w10_hold", 32'(rst_cnt), 32'd40);
    checkOutput("w10_result", 32'(bus.result), 32'd10);
    checkOutput("w10_ovf", 32'(bus.ovf), 32'd0);

    // Window of 20 wraps the 4-bit counter.
    runWindow(8'd20, 0, 1'b0, 1'b0, lat, en_cnt, rst_cnt);
    checkOutput("w20_latency", 32'(lat), 32'd23);
    checkOutput("w20_en_cycles", 32'(en_cnt), 32'd20);
    checkOutput("w20_result", 32'(bus.result), 32'd4);
    checkOutput("w20_ovf", 32'(bus.ovf), 32'd1);

    // Abort during the 5th RUN cycle of a 10-cycle window.
    applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
    idleCycles(4);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("abort_en_low", 32'(bus.cnt_en), 32'd0);
    checkOutput("abort_done_low", 32'(bus.done), 32'd0);
    countRst(rst_cnt);
    checkOutput("abort_hold", 32'(rst_cnt), 32'd40);
    checkOutput("abort_result_kept", 32'(bus.result), 32'd4);
    checkOutput("abort_ovf_kept", 32'(bus.ovf), 32'd1);

    // Abort in SETTLE (window of 3): no result.
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("settle_abort_rst", 32'(bus.cnt_rst), 32'd1);
    checkOutput("settle_abort_no_done", 32'(bus.done), 32'd0);
    countRst(rst_cnt);
    checkOutput("settle_abort_hold", 32'(rst_cnt), 32'd40);

    // Abort in CAPTURE is ignored: done still arrives.
    runWindow(8'd3, 5, 1'b0, 1'b1, lat, en_cnt, rst_cnt);
    checkOutput("capture_abort_latency", 32'(lat), 32'd6);
    checkOutput("capture_abort_result", 32'(bus.result), 32'd3);

    // Zero-length window.
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
    checkOutput("w0_done", 32'(bus.done), 32'd1);
    checkOutput("w0_result", 32'(bus.result), 32'd0);
    checkOutput("w0_busy", 32'(bus.busy), 32'd0);
    idleCycles(1);
    checkOutput("w0_done_pulse", 32'(bus.done), 32'd0);

    // Start while busy is ignored.
    runWindow(8'd5, 3, 1'b1, 1'b0, lat, en_cnt, rst_cnt);
    checkOutput("busy_start_en_cycles", 32'(en_cnt), 32'd5);
    checkOutput("busy_start_result", 32'(bus.result), 32'd5);

    // Window-length boundaries.
    for (int i = 0; i < 4; i++) begin
      runWindow(tbl_win[i], 0, 1'b0, 1'b0, lat, en_cnt, rst_cnt);
      checkOutput("tbl_latency", 32'(lat), 32'(int'(tbl_win[i]) + 3));
      checkOutput("tbl_result", 32'(bus.result), 32'(tbl_res[i]));
      checkOutput("tbl_ovf", 32'(bus.ovf), 32'(tbl_ovf[i]));
    end

    // Reset mid-RUN after a result with overflow.
    runWindow(8'd17, 0, 1'b0, 1'b0, lat, en_cnt, rst_cnt);
    checkOutput("w17_result", 32'(bus.result), 32'd1);
    applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("midrun_rst_en", 32'(bus.cnt_en), 32'd0);
    checkOutput("midrun_rst_cntrst", 32'(bus.cnt_rst), 32'd1);
    checkOutput("midrun_rst_result", 32'(bus.result), 32'd0);
    checkOutput("midrun_rst_ovf", 32'(bus.ovf), 32'd0);
    countRst(rst_cnt);
    checkOutput("midrun_rst_hold", 32'(rst_cnt), 32'd40);

    idleCycles(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
